// File: rtl/axi_vector_pkg.sv
// Types and helpers shared by the AXI-Stream vector writer and reader.
// num_chunks is the single definition of the chunking rule, which keeps writer and reader in agreement.
package axi_vector_pkg;

  typedef enum logic [1:0] {
    STATE__IDLE,
    STATE__SEND,
    STATE__DONE
  } state_t;

  function automatic int unsigned num_chunks(input int unsigned len, input int unsigned width);
    return (len + width - 1) / width;
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream bundle: tdata/tvalid/tlast travel from master to slave, and tready travels back.
interface axi_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axi_write_vector.sv
// Snapshots a wide vector on start and streams it LSB chunk first; tlast is driven when AXI_WRITE_VECTOR_TLAST_EN is defined.
// Latency: the first beat is valid one cycle after start, and done pulses one cycle after the final handshake.
// Backpressure: tvalid stays high through SEND; tdata and tlast hold while tready is low.
module axi_write_vector
  import axi_vector_pkg::*;
#(
  parameter int unsigned MAX_VEC_LENGTH   = 10,
  parameter int unsigned AXI_DATA_WIDTH   = 4,
  parameter int unsigned MAX_VEC_LENGTH_W = (MAX_VEC_LENGTH <= 1) ? 1 : $clog2(MAX_VEC_LENGTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [MAX_VEC_LENGTH_W-1:0] vec_length,
  input  logic [MAX_VEC_LENGTH-1:0]   vec,
  axi_stream_if.master                data_out,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned MAX_CHUNKS        = num_chunks(MAX_VEC_LENGTH, AXI_DATA_WIDTH);
  localparam int unsigned MAX_CHUNKS_ITER_W = (MAX_CHUNKS <= 1) ? 1 : $clog2(MAX_CHUNKS);
  localparam int unsigned PAD_W             = MAX_CHUNKS * AXI_DATA_WIDTH;
`ifdef AXI_WRITE_VECTOR_TLAST_EN
  localparam bit TLAST_EN = 1'b1;
`else
  localparam bit TLAST_EN = 1'b0;
`endif

  state_t                        state_q, state_d;
  logic                          tvalid_q, tvalid_d;
  logic                          tlast_q, tlast_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic [MAX_CHUNKS_ITER_W-1:0]  chunk_iter_q, chunk_iter_d;
  logic [MAX_CHUNKS_ITER_W-1:0]  chunk_end_q, chunk_end_d;
  logic [MAX_VEC_LENGTH_W-1:0]   len_q, len_d;
  logic [PAD_W-1:0]              vec_q, vec_d;

  logic [MAX_VEC_LENGTH_W-1:0]   len_clamped;
  logic [MAX_VEC_LENGTH-1:0]     vec_masked;
  int unsigned                   chunks;

  always_comb begin
    len_clamped = (32'(vec_length) > MAX_VEC_LENGTH) ? MAX_VEC_LENGTH_W'(MAX_VEC_LENGTH) : vec_length;
    for (int i = 0; i < int'(MAX_VEC_LENGTH); i++) begin
      vec_masked[i] = vec[i] & (32'(i) < 32'(len_clamped));
    end
    chunks = num_chunks(32'(len_clamped), AXI_DATA_WIDTH);

    state_d      = state_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    chunk_iter_d = chunk_iter_q;
    chunk_end_d  = chunk_end_q;
    len_d        = len_q;
    vec_d        = vec_q;

    case (state_q)
      STATE__IDLE: begin
        if (start) begin
          len_d                       = len_clamped;
          vec_d                       = '0;
          vec_d[MAX_VEC_LENGTH-1:0]   = vec_masked;
          chunk_end_d                 = MAX_CHUNKS_ITER_W'(chunks - 1);
          chunk_iter_d                = '0;
          busy_d                      = 1'b1;
          if (len_clamped == '0) begin
            state_d = STATE__DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = STATE__SEND;
            tvalid_d = 1'b1;
            tlast_d  = TLAST_EN && (chunk_end_d == '0);
          end
        end
      end
      STATE__SEND: begin
        if (data_out.tready) begin
          if (chunk_iter_q == chunk_end_q) begin
            state_d      = STATE__DONE;
            tvalid_d     = 1'b0;
            tlast_d      = 1'b0;
            done_d       = 1'b1;
            chunk_iter_d = '0;
          end else begin
            chunk_iter_d = chunk_iter_q + MAX_CHUNKS_ITER_W'(1);
            tlast_d      = TLAST_EN && (chunk_iter_d == chunk_end_q);
          end
        end
      end
      STATE__DONE: begin
        state_d = STATE__IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = STATE__IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // The snapshot registers carry no reset; their contents only matter once start has loaded them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= STATE__IDLE;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      chunk_iter_q <= '0;
    end else begin
      state_q      <= state_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      chunk_iter_q <= chunk_iter_d;
      chunk_end_q  <= chunk_end_d;
      len_q        <= len_d;
      vec_q        <= vec_d;
    end
  end

  assign data_out.tdata  = AXI_DATA_WIDTH'(vec_q >> (32'(chunk_iter_q) * AXI_DATA_WIDTH));
  assign data_out.tvalid = tvalid_q;
  assign data_out.tlast  = tlast_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
